pwm_ramp_generator: RTL

Drives the staircase PWM ramp that the comparator-capture block samples against. Sweeps an 8-bit duty cycle from 0 to 255, holding each step for a programmable number of PWM periods so the external RC filter can settle. Exports the live duty value and sweep framing pulses. Sits between the top-level enable/control logic and the capture block's `duty_cycle` input, with `pwm_out` routed to the RC filter pin.

---
 rtl/pwm_pkg.sv | 28 ++
 rtl/pwm_core.sv | 48 ++++
 rtl/pwm_ramp_generator.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// ============================================================================
// Module      : pwm_pkg
// Description : Shared state type, default sizing constants and a counter
//               width helper for the PWM ramp generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP      = 2'd1,
        DISCHARGE = 2'd2
    } pwm_state_t;

    localparam int PWM_WIDTH_DEF     = 8;
    localparam int PWM_SETTLE_DEF    = 16;
    localparam int PWM_DISCHARGE_DEF = 64;

    // A count of 1 still needs a 1-bit register to stay legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_core.sv
// ============================================================================
// Module      : pwm_core
// Description : Free-running PWM period counter with registered duty compare,
//               a force-low override and an end-of-period strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_core
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             force_low,
    input  logic [WIDTH-1:0] duty,
    output logic             pwm_out,
    output logic             period_wrap
);

    logic [WIDTH-1:0] pwm_cnt_q;
    logic [WIDTH-1:0] pwm_cnt_d;
    logic             pwm_out_q;
    logic             pwm_out_d;

    always_comb begin
        pwm_cnt_d = clear ? '0 : (pwm_cnt_q + WIDTH'(1));
        pwm_out_d = !force_low && (pwm_cnt_q < duty);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_q <= '0;
            pwm_out_q <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            pwm_out_q <= pwm_out_d;
        end
    end

    assign pwm_out     = pwm_out_q;
    assign period_wrap = (pwm_cnt_q == '1);

endmodule

`default_nettype wire

// File: rtl/pwm_ramp_generator.sv
// ============================================================================
// Module      : pwm_ramp_generator
// Description : Staircase PWM duty sweep 0..max, each step held for
//               SETTLE_PERIODS PWM periods, with sweep framing pulses.
//               Define PWM_RAMP_DISCHARGE_EN to build the forced-low
//               DISCHARGE gap between sweeps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_ramp_generator
    import pwm_pkg::*;
#(
    parameter int WIDTH             = PWM_WIDTH_DEF,
    parameter int SETTLE_PERIODS    = PWM_SETTLE_DEF,
    parameter int DISCHARGE_PERIODS = PWM_DISCHARGE_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    output logic             pwm_out,
    output logic [WIDTH-1:0] duty_cycle,
    output logic             sweep_start,
    output logic             sweep_done
);

    localparam int            SW          = cnt_width(SETTLE_PERIODS);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_PERIODS - 1);

    if ((SETTLE_PERIODS < 1) || (DISCHARGE_PERIODS < 1)) begin : g_bad_params
        $error("pwm_ramp_generator: SETTLE_PERIODS and DISCHARGE_PERIODS must be >= 1");
    end

    pwm_state_t       state_q;
    pwm_state_t       state_d;
    logic [WIDTH-1:0] duty_q;
    logic [WIDTH-1:0] duty_d;
    logic [SW-1:0]    settle_q;
    logic [SW-1:0]    settle_d;
    logic             sweep_start_q;
    logic             sweep_start_d;
    logic             sweep_done_q;
    logic             sweep_done_d;

    logic             w_period_wrap;
    logic             w_settle_last;
    logic             w_duty_max;
    logic             w_sweep_end;
    logic             w_cnt_clear;
    logic             w_force_low;

    assign w_settle_last = (settle_q == SETTLE_LAST);
    assign w_duty_max    = (duty_q == '1);
    assign w_sweep_end   = w_period_wrap && w_settle_last && w_duty_max;

    // The counter holds at 0 through IDLE so the first RAMP cycle sees pwm_cnt=0.
    assign w_cnt_clear = (state_q == IDLE) || !enable;
    // Keyed off the next state so the registered output is already low on entry.
    assign w_force_low = (state_d != RAMP);

    pwm_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (w_cnt_clear),
        .force_low   (w_force_low),
        .duty        (duty_q),
        .pwm_out     (pwm_out),
        .period_wrap (w_period_wrap)
    );

`ifdef PWM_RAMP_DISCHARGE_EN
    localparam int            DW             = cnt_width(DISCHARGE_PERIODS);
    localparam logic [DW-1:0] DISCHARGE_LAST = DW'(DISCHARGE_PERIODS - 1);

    logic [DW-1:0] discharge_q;
    logic [DW-1:0] discharge_d;
    logic          w_discharge_last;

    assign w_discharge_last = (discharge_q == DISCHARGE_LAST);

    always_comb begin
        discharge_d = discharge_q;
        if (state_d == IDLE) begin
            discharge_d = '0;
        end else if ((state_q == DISCHARGE) && w_period_wrap) begin
            discharge_d = w_discharge_last ? '0 : (discharge_q + DW'(1));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            discharge_q <= '0;
        end else begin
            discharge_q <= discharge_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            duty_q        <= '0;
            settle_q      <= '0;
            sweep_start_q <= 1'b0;
            sweep_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            duty_q        <= duty_d;
            settle_q      <= settle_d;
            sweep_start_q <= sweep_start_d;
            sweep_done_q  <= sweep_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = RAMP;
                RAMP: begin
`ifdef PWM_RAMP_DISCHARGE_EN
                    if (w_sweep_end) begin
                        state_d = DISCHARGE;
                    end
`endif
                end
`ifdef PWM_RAMP_DISCHARGE_EN
                DISCHARGE: begin
                    if (w_period_wrap && w_discharge_last) begin
                        state_d = RAMP;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        duty_d        = duty_q;
        settle_d      = settle_q;
        sweep_start_d = 1'b0;
        sweep_done_d  = 1'b0;
        if (state_d == IDLE) begin
            duty_d   = '0;
            settle_d = '0;
        end else begin
            case (state_q)
                IDLE: sweep_start_d = 1'b1;
                RAMP: begin
                    if (w_period_wrap) begin
                        if (!w_settle_last) begin
                            settle_d = settle_q + SW'(1);
                        end else begin
                            settle_d = '0;
                            if (w_sweep_end) begin
                                sweep_done_d = 1'b1;
                                duty_d       = '0;
`ifndef PWM_RAMP_DISCHARGE_EN
                                // Without a discharge gap the next sweep starts immediately.
                                sweep_start_d = 1'b1;
`endif
                            end else begin
                                duty_d = duty_q + WIDTH'(1);
                            end
                        end
                    end
                end
`ifdef PWM_RAMP_DISCHARGE_EN
                DISCHARGE: begin
                    duty_d = '0;
                    if (state_d == RAMP) begin
                        sweep_start_d = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign duty_cycle  = duty_q;
    assign sweep_start = sweep_start_q;
    assign sweep_done  = sweep_done_q;

endmodule

`default_nettype wire
